buffer_transfer_scheduler: RTL and testbench



---
 rtl/buffer_transfer_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_buffer_transfer_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_transfer_scheduler.sv
// Per-channel descriptor queues that are split into fixed-size transfer requests,
// round-robin arbitrated onto one request port and limited by per-channel credits.
module buffer_transfer_scheduler #(
    parameter int NUM_CHANNELS    = 4,
    parameter int QUEUE_DEPTH     = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TRANSFER_BYTES  = 65536,
    parameter int VADDR_W         = 32,
    parameter int SIZE_W          = 16,
    localparam int CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [CH_W-1:0]         enq_channel,
    input  logic [VADDR_W-1:0]      enq_vaddr,
    input  logic [SIZE_W-1:0]       enq_size,
    output logic                    enq_err,
    input  logic                    flush_valid,
    input  logic [CH_W-1:0]         flush_channel,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [CH_W-1:0]         req_channel,
    output logic [VADDR_W-1:0]      req_vaddr,
    output logic                    req_last,
    input  logic                    ack_valid,
    input  logic [CH_W-1:0]         ack_channel,
    output logic                    ack_err,
    output logic [NUM_CHANNELS-1:0] busy
);

    localparam int AW    = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0] full, empty, eligible, is_last;
    logic [NUM_CHANNELS-1:0] push, flush, load, ack_dec, out_zero, busy_next;
    logic [NUM_CHANNELS-1:0][VADDR_W-1:0] head_addr;

    logic enq_in_range, ack_in_range, enq_fire, load_en;
    logic enq_full_sel, ack_zero_sel;
    logic grant_valid, grant_last;
    logic [CH_W-1:0]    grant_ch;
    logic [VADDR_W-1:0] grant_addr;
    int                 idx;

    logic                    req_valid_reg, req_last_reg, enq_err_reg, ack_err_reg;
    logic [CH_W-1:0]         req_channel_reg, rr_ptr_reg;
    logic [VADDR_W-1:0]      req_vaddr_reg;
    logic [NUM_CHANNELS-1:0] busy_reg;

    always_comb begin
        enq_in_range = {1'b0, enq_channel} < NUM_CH_L;
        ack_in_range = {1'b0, ack_channel} < NUM_CH_L;
        enq_full_sel = 1'b0;
        ack_zero_sel = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (enq_channel == CH_W'(c)) enq_full_sel = full[c];
            if (ack_channel == CH_W'(c)) ack_zero_sel = out_zero[c];
        end
    end

    assign enq_ready = ~enq_in_range | ~enq_full_sel;
    assign enq_fire  = enq_valid & enq_ready;
    // The output register may reload whenever it is empty or draining this cycle.
    assign load_en   = ~req_valid_reg | req_ready;

    // Search starts one past the last granted channel.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        grant_addr  = '0;
        grant_last  = 1'b0;
        idx         = 0;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NUM_CHANNELS;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_ch    = CH_W'(idx);
                grant_addr  = head_addr[idx];
                grant_last  = is_last[idx];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [VADDR_W-1:0] mem_vaddr [QUEUE_DEPTH];
            logic [SIZE_W-1:0]  mem_size  [QUEUE_DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
            logic [SIZE_W-1:0]  offset_reg, offset_next, head_size;
            logic [VADDR_W-1:0] head_vaddr;
            logic [OUT_W-1:0]   out_reg, out_next;

            // A flush on the same cycle wins over an enqueue to this channel.
            assign flush[gi]   = flush_valid && (flush_channel == CH_W'(gi));
            assign push[gi]    = enq_fire && (enq_channel == CH_W'(gi)) && (enq_size != '0) && !flush[gi];
            assign load[gi]    = load_en && grant_valid && (grant_ch == CH_W'(gi));
            assign ack_dec[gi] = ack_valid && (ack_channel == CH_W'(gi)) && !out_zero[gi];

            assign head_vaddr   = mem_vaddr[rd_ptr_reg[AW-1:0]];
            assign head_size    = mem_size[rd_ptr_reg[AW-1:0]];
            assign empty[gi]    = (wr_ptr_reg == rd_ptr_reg);
            assign full[gi]     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign out_zero[gi] = (out_reg == '0);
            assign eligible[gi] = !empty[gi] && (out_reg < OUT_W'(MAX_OUTSTANDING));
            assign is_last[gi]  = (offset_reg == head_size - SIZE_W'(1));
            assign head_addr[gi] = head_vaddr + VADDR_W'(offset_reg) * VADDR_W'(TRANSFER_BYTES);
            assign busy_next[gi] = (wr_ptr_next != rd_ptr_next) || (out_next != '0);

            always_ff @(posedge aclk) begin
                if (push[gi]) begin
                    mem_vaddr[wr_ptr_reg[AW-1:0]] <= enq_vaddr;
                    mem_size[wr_ptr_reg[AW-1:0]]  <= enq_size;
                end
            end

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                offset_next = offset_reg;
                out_next    = out_reg;
                if (push[gi]) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                if (flush[gi]) begin
                    rd_ptr_next = wr_ptr_reg;
                    offset_next = '0;
                end else if (load[gi]) begin
                    if (is_last[gi]) begin
                        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
                        offset_next = '0;
                    end else begin
                        offset_next = offset_reg + SIZE_W'(1);
                    end
                end
                // A credit is taken at load time, so a stalled request still holds one.
                if (load[gi] && !ack_dec[gi])      out_next = out_reg + OUT_W'(1);
                else if (!load[gi] && ack_dec[gi]) out_next = out_reg - OUT_W'(1);
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    offset_reg <= '0;
                    out_reg    <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    offset_reg <= offset_next;
                    out_reg    <= out_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            req_valid_reg   <= 1'b0;
            req_channel_reg <= '0;
            req_vaddr_reg   <= '0;
            req_last_reg    <= 1'b0;
            rr_ptr_reg      <= '0;
            enq_err_reg     <= 1'b0;
            ack_err_reg     <= 1'b0;
            busy_reg        <= '0;
        end else begin
            enq_err_reg <= enq_fire && (!enq_in_range || (enq_size == '0));
            ack_err_reg <= ack_valid && (!ack_in_range || ack_zero_sel);
            busy_reg    <= busy_next;
            if (load_en) begin
                req_valid_reg <= grant_valid;
                if (grant_valid) begin
                    req_channel_reg <= grant_ch;
                    req_vaddr_reg   <= grant_addr;
                    req_last_reg    <= grant_last;
                    rr_ptr_reg      <= grant_ch;
                end
            end
        end
    end

    assign req_valid   = req_valid_reg;
    assign req_channel = req_channel_reg;
    assign req_vaddr   = req_vaddr_reg;
    assign req_last    = req_last_reg;
    assign enq_err     = enq_err_reg;
    assign ack_err     = ack_err_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_buffer_transfer_scheduler.sv
// Directed bench: five channels (so channel 5 is out of range), two credits per
// channel and a four-deep queue, with expected values worked out by hand.
module tb_buffer_transfer_scheduler;

    localparam int NC = 5;
    localparam int CW = 3;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [CW-1:0] enq_channel = '0;
    logic [31:0]   enq_vaddr = '0;
    logic [7:0]    enq_size = '0;
    logic          enq_err;
    logic          flush_valid = 1'b0;
    logic [CW-1:0] flush_channel = '0;
    logic          req_valid;
    logic          req_ready = 1'b1;
    logic [CW-1:0] req_channel;
    logic [31:0]   req_vaddr;
    logic          req_last;
    logic          ack_valid = 1'b0;
    logic [CW-1:0] ack_channel = '0;
    logic          ack_err;
    logic [NC-1:0] busy;

    int n_cmp = 0;
    int n_err = 0;
    logic auto_ack = 1'b0;

    buffer_transfer_scheduler #(
        .NUM_CHANNELS(NC), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2),
        .TRANSFER_BYTES(65536), .VADDR_W(32), .SIZE_W(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_channel(enq_channel),
        .enq_vaddr(enq_vaddr), .enq_size(enq_size), .enq_err(enq_err),
        .flush_valid(flush_valid), .flush_channel(flush_channel),
        .req_valid(req_valid), .req_ready(req_ready), .req_channel(req_channel),
        .req_vaddr(req_vaddr), .req_last(req_last),
        .ack_valid(ack_valid), .ack_channel(ack_channel), .ack_err(ack_err),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    // Advance one edge; optionally acknowledge whatever is handshaking this cycle.
    task automatic tick();
        @(posedge aclk);
        #1;
        if (auto_ack) begin
            ack_valid   = req_valid & req_ready;
            ack_channel = req_channel;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input int ch, input logic [31:0] va, input logic [7:0] sz);
        enq_valid   = 1'b1;
        enq_channel = CW'(ch);
        enq_vaddr   = va;
        enq_size    = sz;
    endtask

    task automatic check_req(input string tag, input int ch, input logic [31:0] va, input logic last);
        check({tag, "_valid"}, 64'(req_valid), 64'd1);
        check({tag, "_ch"}, 64'(req_channel), 64'(ch));
        check({tag, "_vaddr"}, 64'(req_vaddr), 64'(va));
        check({tag, "_last"}, 64'(req_last), 64'(last));
        $display("req ch=%0d vaddr=0x%0h last=%0d", req_channel, req_vaddr, req_last);
    endtask

    int          rr_ch   [6] = '{0, 1, 3, 0, 1, 3};
    logic [31:0] rr_addr [6] = '{32'h100000, 32'h200000, 32'h300000, 32'h110000, 32'h210000, 32'h310000};
    logic        rr_last [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset state
        tick(); tick();
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_req_vaddr", 64'(req_vaddr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_errs", 64'({enq_err, ack_err}), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        aresetn = 1'b1;
        tick();

        // Single buffer, 3 transfers, 2-cycle latency
        auto_ack = 1'b1;
        enq(0, 32'h1000, 8'd3);
        tick();
        enq_valid = 1'b0;
        check("single_latency", 64'(req_valid), 64'd0);
        tick(); check_req("single0", 0, 32'h1000, 1'b0);
        check("single_busy", 64'(busy), 64'b00001);
        tick(); check_req("single1", 0, 32'h11000, 1'b0);
        tick(); check_req("single2", 0, 32'h21000, 1'b1);
        tick();
        check("single_done", 64'(req_valid), 64'd0);
        check("single_idle", 64'(busy), 64'd0);

        // Round-robin across channels 0, 1, 3 with no idle cycles
        enq(0, 32'h100000, 8'd2);
        tick();
        enq(1, 32'h200000, 8'd2);
        tick(); check_req("rr0", rr_ch[0], rr_addr[0], rr_last[0]);
        enq(3, 32'h300000, 8'd2);
        tick(); check_req("rr1", rr_ch[1], rr_addr[1], rr_last[1]);
        enq_valid = 1'b0;
        for (int i = 2; i < 6; i++) begin
            tick(); check_req($sformatf("rr%0d", i), rr_ch[i], rr_addr[i], rr_last[i]);
        end
        tick();
        check("rr_done", 64'(req_valid), 64'd0);

        // Credit limit: two in flight, one ack releases exactly one more
        auto_ack  = 1'b0;
        ack_valid = 1'b0;
        enq(2, 32'h5000, 8'd5);
        tick();
        enq_valid = 1'b0;
        tick(); check_req("cred0", 2, 32'h5000, 1'b0);
        tick(); check_req("cred1", 2, 32'h15000, 1'b0);
        tick(); check("cred_stall0", 64'(req_valid), 64'd0);
        tick(); check("cred_stall1", 64'(req_valid), 64'd0);
        ack_valid = 1'b1; ack_channel = 3'd2;
        tick();
        ack_valid = 1'b0;
        check("cred_ack_lat", 64'(req_valid), 64'd0);
        check("cred_ack_noerr", 64'(ack_err), 64'd0);
        tick(); check_req("cred2", 2, 32'h25000, 1'b0);
        tick(); check("cred_stall2", 64'(req_valid), 64'd0);

        // Ack errors: zero outstanding, then out-of-range channel
        ack_valid = 1'b1; ack_channel = 3'd4;
        tick();
        ack_valid = 1'b0;
        check("ackerr_zero", 64'(ack_err), 64'd1);
        tick();
        check("ackerr_pulse", 64'(ack_err), 64'd0);
        ack_valid = 1'b1; ack_channel = 3'd6;
        tick();
        ack_valid = 1'b0;
        check("ackerr_range", 64'(ack_err), 64'd1);

        // Fill ch 2 while its credits are exhausted
        flush_valid = 1'b1; flush_channel = 3'd2;
        tick();
        flush_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enq(2, 32'h7000 + 32'(i) * 32'h100, 8'd1);
            #1;
            check($sformatf("fill_ready%0d", i), 64'(enq_ready), 64'd1);
            tick();
        end
        #1;
        check("fill_full", 64'(enq_ready), 64'd0);
        enq_channel = 3'd0;
        #1;
        check("fill_other_ready", 64'(enq_ready), 64'd1);
        enq_valid = 1'b0;
        check("fill_no_req", 64'(req_valid), 64'd0);
        check("fill_busy", 64'(busy), 64'b00100);

        // Enqueue errors: out-of-range channel, then zero size
        enq(5, 32'h9000, 8'd1);
        #1;
        check("enqerr_range_ready", 64'(enq_ready), 64'd1);
        tick();
        enq_valid = 1'b0;
        check("enqerr_range", 64'(enq_err), 64'd1);
        tick();
        check("enqerr_pulse", 64'(enq_err), 64'd0);
        check("enqerr_range_noreq", 64'(req_valid), 64'd0);
        enq(0, 32'h9000, 8'd0);
        tick();
        enq_valid = 1'b0;
        check("enqerr_zero", 64'(enq_err), 64'd1);
        tick();
        check("enqerr_zero_noreq", 64'(req_valid), 64'd0);
        check("enqerr_zero_busy", 64'(busy), 64'b00100);

        // Drain ch 2: flush the queue and return both credits
        flush_valid = 1'b1; flush_channel = 3'd2;
        ack_valid = 1'b1; ack_channel = 3'd2;
        tick();
        flush_valid = 1'b0;
        tick();
        ack_valid = 1'b0;
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_noerr", 64'(ack_err), 64'd0);

        // Backpressure: outputs frozen for 10 cycles, then an unbroken sequence
        auto_ack  = 1'b1;
        req_ready = 1'b0;
        enq(1, 32'h40000, 8'd3);
        tick();
        enq_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); check_req($sformatf("bp_hold%0d", i), 1, 32'h40000, 1'b0);
        end
        req_ready = 1'b1;
        ack_valid = 1'b1; ack_channel = 3'd1;
        tick(); check_req("bp1", 1, 32'h50000, 1'b0);
        tick(); check_req("bp2", 1, 32'h60000, 1'b1);
        tick();
        check("bp_done", 64'(req_valid), 64'd0);
        check("bp_busy", 64'(busy), 64'd0);

        // Flush ch 1 while its first request is stalled in the output register
        auto_ack  = 1'b0;
        ack_valid = 1'b0;
        req_ready = 1'b0;
        enq(1, 32'h80000, 8'd4);
        tick();
        enq_valid = 1'b0;
        tick(); check_req("flush_pend", 1, 32'h80000, 1'b0);
        flush_valid = 1'b1; flush_channel = 3'd1;
        tick();
        flush_valid = 1'b0;
        check_req("flush_kept", 1, 32'h80000, 1'b0);
        req_ready = 1'b1;
        tick();
        check("flush_no_more", 64'(req_valid), 64'd0);
        check("flush_busy_held", 64'(busy), 64'b00010);
        tick();
        check("flush_still_none", 64'(req_valid), 64'd0);
        ack_valid = 1'b1; ack_channel = 3'd1;
        tick();
        ack_valid = 1'b0;
        check("flush_busy_clear", 64'(busy), 64'd0);
        check("flush_ack_ok", 64'(ack_err), 64'd0);

        // Reset in the middle of a burst
        auto_ack = 1'b1;
        enq(3, 32'hA000, 8'd8);
        tick();
        enq_valid = 1'b0;
        tick(); check_req("mid0", 3, 32'hA000, 1'b0);
        tick(); check_req("mid1", 3, 32'h1A000, 1'b0);
        aresetn = 1'b0;
        tick();
        check("mrst_req_valid", 64'(req_valid), 64'd0);
        check("mrst_req_ch", 64'(req_channel), 64'd0);
        check("mrst_req_vaddr", 64'(req_vaddr), 64'd0);
        check("mrst_req_last", 64'(req_last), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_errs", 64'({enq_err, ack_err}), 64'd0);
        aresetn   = 1'b1;
        auto_ack  = 1'b0;
        ack_valid = 1'b0;
        tick();
        check("mrst_discarded", 64'(req_valid), 64'd0);
        check("mrst_busy_after", 64'(busy), 64'd0);
        ack_valid = 1'b1; ack_channel = 3'd3;
        tick();
        ack_valid = 1'b0;
        check("mrst_no_credit", 64'(ack_err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
